// File: rtl/bin2bcd_serial.sv
// Serial signed-binary to packed-BCD converter (double dabble), one bit per clock.
// Define BIN2BCD_BLANK_LEADING_EN to replace leading zero digits with the blank code 4'hF.
module bin2bcd_serial #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 6
) (
  input  logic                  clock_50m_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  neg_o,
  output logic                  overflow_o,
  output logic [4*DIGITS-1:0]   bcd_out_o
);

  // Number of decimal digits needed to hold 2^(WIDTH-1), the largest magnitude.
  function automatic int calcScratchDigits(input int w);
    logic [127:0] p;
    int           n;
    p = 128'd1 << (w - 1);
    n = 0;
    while (p != 128'd0) begin
      p = p / 128'd10;
      n++;
    end
    return n;
  endfunction

  localparam int NSCR = calcScratchDigits(WIDTH);
  localparam int NOUT = (DIGITS > NSCR) ? DIGITS : NSCR;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef BIN2BCD_BLANK_LEADING_EN
  localparam logic [4*DIGITS-1:0] BCD_RST = {(4*DIGITS){1'b1}} << 4;
`else
  localparam logic [4*DIGITS-1:0] BCD_RST = '0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*NSCR-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  negCap_q, negCap_d;
  logic                  negOut_q, negOut_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;

  logic [4*NSCR-1:0]     scratchAdj;
  logic [4*NSCR-1:0]     scratchShift;
  logic [4*NOUT-1:0]     scratchExt;
  logic [4*DIGITS-1:0]   bcdFinal;
  logic                  ovfFinal;

  always_comb begin
    scratchAdj = scratch_q;
    for (int i = 0; i < NSCR; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratchAdj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign scratchShift = {scratchAdj[4*NSCR-2:0], mag_q[WIDTH-1]};

  // Zero-extend so the display width may exceed the scratch width.
  always_comb begin
    scratchExt              = '0;
    scratchExt[4*NSCR-1:0]  = scratchShift;
  end

  assign ovfFinal = |(scratchExt >> (4 * DIGITS));

`ifdef BIN2BCD_BLANK_LEADING_EN
  logic leadZero;

  always_comb begin
    bcdFinal = scratchExt[4*DIGITS-1:0];
    leadZero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leadZero && (bcdFinal[4*i +: 4] == 4'h0)) begin
        bcdFinal[4*i +: 4] = 4'hF;
      end else begin
        leadZero = 1'b0;
      end
    end
  end
`else
  assign bcdFinal = scratchExt[4*DIGITS-1:0];
`endif

  always_ff @(posedge clock_50m_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      negCap_q  <= 1'b0;
      negOut_q  <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= BCD_RST;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      negCap_q  <= negCap_d;
      negOut_q  <= negOut_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
    end
  end

  // Results load on the final shift so they are already valid while done is high.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    negCap_d  = negCap_q;
    negOut_d  = negOut_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = SHIFT;
          mag_d     = value_i[WIDTH-1] ? (~value_i + WIDTH'(1)) : value_i;
          negCap_d  = value_i[WIDTH-1];
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        busy_o    = 1'b1;
        scratch_d = scratchShift;
        mag_d     = mag_q << 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          bcd_d    = bcdFinal;
          ovf_d    = ovfFinal;
          negOut_d = negCap_q;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign neg_o      = negOut_q;
  assign overflow_o = ovf_q;
  assign bcd_out_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: table of conversions plus handshake, ignore and reset sequences.
module tb_bin2bcd_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        neg;
  logic        ovf;
  logic [23:0] bcd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] value;
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  vec_t vecs[12];
  exp_t expQ[$];

`ifdef BIN2BCD_BLANK_LEADING_EN
  localparam logic [23:0] BCD_RST = 24'hFFFFF0;
`else
  localparam logic [23:0] BCD_RST = 24'h000000;
`endif

  bin2bcd_serial #(.WIDTH(32), .DIGITS(6)) dut (
    .clock_50m_i (clk),
    .rst_i       (rst),
    .start_i     (start),
    .value_i     (value),
    .busy_o      (busy),
    .done_o      (done),
    .neg_o       (neg),
    .overflow_o  (ovf),
    .bcd_out_o   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] blankExp(input logic [23:0] b);
    logic [23:0] r;
    r = b;
`ifdef BIN2BCD_BLANK_LEADING_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = 5; i >= 1; i--) begin
        if (lead && (r[4*i +: 4] == 4'h0)) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; start is sampled at the following posedge.
  task automatic applyStimulus(input logic [31:0] v, input logic [23:0] eBcd,
                               input logic eNeg, input logic eOvf);
    exp_t e;
    e.bcd = blankExp(eBcd);
    e.neg = eNeg;
    e.ovf = eOvf;
    expQ.push_back(e);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = $urandom;
  endtask

  task automatic compareResult(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: done seen with no expected entry", tag);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, " bcd"}, 64'(bcd), 64'(e.bcd));
      checkOutput({tag, " neg"}, 64'(neg), 64'(e.neg));
      checkOutput({tag, " ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  task automatic waitDone(input string tag, output int cycles, output int busyCnt);
    cycles  = 0;
    busyCnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      cycles = c;
      if (busy) busyCnt++;
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no done after %0d cycles, required 33", tag, cycles);
    end
  endtask

  initial begin
    int cycles;
    int busyCnt;
    int doneAt;
    int doneSeen;
    logic [23:0] held;

    vecs[0]  = '{32'd123456,      24'h123456, 1'b0, 1'b0};
    vecs[1]  = '{-32'sd12345,     24'h012345, 1'b1, 1'b0};
    vecs[2]  = '{32'd0,           24'h000000, 1'b0, 1'b0};
    vecs[3]  = '{32'd1000000,     24'h000000, 1'b0, 1'b1};
    vecs[4]  = '{32'h80000000,    24'h483648, 1'b1, 1'b1};
    vecs[5]  = '{32'd999999,      24'h999999, 1'b0, 1'b0};
    vecs[6]  = '{-32'sd1,         24'h000001, 1'b1, 1'b0};
    vecs[7]  = '{32'h7FFFFFFF,    24'h483647, 1'b0, 1'b1};
    vecs[8]  = '{-32'sd999999,    24'h999999, 1'b1, 1'b0};
    vecs[9]  = '{32'd100000,      24'h100000, 1'b0, 1'b0};
    vecs[10] = '{32'd1000,        24'h001000, 1'b0, 1'b0};
    vecs[11] = '{-32'sd1000001,   24'h000001, 1'b1, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset bcd",  64'(bcd),  64'(BCD_RST));
    checkOutput("reset neg",  64'(neg),  64'd0);
    checkOutput("reset ovf",  64'(ovf),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].value, vecs[i].bcd, vecs[i].neg, vecs[i].ovf);
      waitDone($sformatf("vec%0d", i), cycles, busyCnt);
      checkOutput($sformatf("vec%0d latency", i), 64'(cycles), 64'd33);
      checkOutput($sformatf("vec%0d busy cycles", i), 64'(busyCnt), 64'd33);
      compareResult($sformatf("vec%0d", i));
      held = bcd;
      @(negedge clk);
      checkOutput($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
      checkOutput($sformatf("vec%0d idle busy", i), 64'(busy), 64'd0);
      checkOutput($sformatf("vec%0d hold bcd", i), 64'(bcd), 64'(held));
    end

    // Starts at +5 and on the done cycle must be dropped.
    applyStimulus(32'd999999, 24'h999999, 1'b0, 1'b0);
    doneAt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5 || c == 33) begin
        start = 1'b1;
        value = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        doneAt = c;
        compareResult("ignore");
        break;
      end
    end
    checkOutput("ignore latency", 64'(doneAt), 64'd33);
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore no requeue busy", 64'(busy), 64'd0);
    applyStimulus(32'd5, 24'h000005, 1'b0, 1'b0);
    waitDone("after ignore", cycles, busyCnt);
    checkOutput("after ignore latency", 64'(cycles), 64'd33);
    compareResult("after ignore");
    @(negedge clk);

    // Reset mid-conversion discards the partial result.
    applyStimulus(32'd123456, 24'h123456, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset bcd",  64'(bcd),  64'(BCD_RST));
    checkOutput("midreset neg",  64'(neg),  64'd0);
    checkOutput("midreset ovf",  64'(ovf),  64'd0);
    void'(expQ.pop_back());
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midreset stray done", 64'(doneSeen), 64'd0);
    applyStimulus(32'd42, 24'h000042, 1'b0, 1'b0);
    waitDone("after reset", cycles, busyCnt);
    checkOutput("after reset latency", 64'(cycles), 64'd33);
    compareResult("after reset");
    @(negedge clk);

    checkOutput("scoreboard empty", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_serial.md
Name: bin2bcd_serial

Overview:
- Sequential signed-binary to BCD converter using shift-and-add-3 (double dabble).
- Sits between the calculator's display-data path and the seven-segment scanning stage.
- Takes a signed two's-complement result and produces a sign flag, DIGITS packed BCD digits and an overflow flag.
- Single-cycle start/done handshake; one conversion at a time.

Parameters:
- WIDTH, 32, bit width of the signed input value.
- DIGITS, 6, number of BCD digits presented on bcd_out (display width).

Ports:
- clock_50m  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  conversion request; sampled only while busy=0.
- value  input  WIDTH  signed two's-complement operand; captured on the accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse; result outputs valid from this cycle onward.
- neg  output  1  1 when the captured value < 0.
- overflow  output  1  1 when |value| > 10^DIGITS - 1.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (LSD) in [3:0].

Behaviour:
- Reset, synchronous and active-high:
  - State goes to IDLE.
  - busy=0, done=0, neg=0, overflow=0, bcd_out=0 (or as set by the optional feature).
  - Counter and scratch registers cleared.
  - Applies even mid-conversion; the partial result is discarded.
- Internal scratch register:
  - Holds NSCR BCD digits, where NSCR is the minimum number of digits that holds 2^(WIDTH-1). NSCR=10 for WIDTH=32.
  - Used for overflow detection independent of DIGITS.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1, go to SHIFT:
    - mag <= |value| as an unsigned WIDTH-bit quantity; -2^(WIDTH-1) maps to 2^(WIDTH-1), with no overflow in the magnitude.
    - neg_r <= value[WIDTH-1].
    - scratch <= 0, cnt <= 0.
  - Result outputs hold their previous values.
- SHIFT, one iteration per cycle, WIDTH cycles total:
  - Each scratch digit >= 5 gets +3.
  - Then {scratch, mag} is shifted left by 1.
  - cnt increments; after the iteration where cnt == WIDTH-1, go to DONE.
- DONE, one cycle:
  - done=1, busy=1.
  - bcd_out <= low DIGITS digits of scratch.
  - overflow <= OR of all scratch digits above DIGITS-1.
  - neg <= neg_r. neg reflects the input sign even when the magnitude is 0; it is never 1 for value=0.
  - Next state is IDLE.
- Latency: accepted start at cycle N gives done=1 at cycle N+WIDTH+1 (33 for WIDTH=32). Next start is accepted at cycle N+WIDTH+2 at the earliest.
- start while busy=1, including during the DONE cycle, is ignored and not queued.
- value changes after capture have no effect on the running conversion.
- Overflow case: bcd_out still carries the low DIGITS digits; the consumer decides how to display the error.
- Outputs are updated only in DONE. Between conversions they are stable, so a scanning display can read them asynchronously to the handshake.

Optional Feature:
- Macro: BIN2BCD_BLANK_LEADING_EN.
- Defined:
  - In the DONE cycle, leading zero digits of bcd_out (from MSD down) are replaced with 4'hF, the blank code.
  - Digit 0 is never blanked, so value 0 shows a single 0.
  - overflow and neg are unaffected.
  - The reset value of bcd_out is all 4'hF except digit 0, which is 4'h0.
- Undefined: leading zeros are output as 4'h0; no extra logic is instantiated.

Test Plan:
- rst, then start with value=123456 -> done exactly 33 cycles after start; bcd_out=24'h123456, neg=0, overflow=0; busy high for 33 cycles.
- value=-12345 -> neg=1, overflow=0, bcd_out=24'h012345 (24'hF12345 with BIN2BCD_BLANK_LEADING_EN).
- value=0 -> bcd_out=24'h000000 (24'hFFFFF0 with the macro), neg=0; then value=1000000 -> overflow=1, bcd_out=24'h000000.
- value=-2147483648 -> neg=1, overflow=1, bcd_out=24'h483648, no X/garbage from the magnitude computation.
- Start 999999; pulse start with value=5 at cycles +5 and +33 (the done cycle) -> both ignored; result is 24'h999999; a start at +34 with 5 yields 24'h000005.
- Start 123456; assert rst at cycle +10 -> next cycle busy=0, outputs at reset values, no done pulse; a subsequent start 42 completes normally with bcd_out=24'h000042.
